// File: rtl/multiplier_accumulator_stage.sv
// multiplier_accumulator_stage: 48-bit signed MAC accumulator stage with optional P register.
// Define ACC_SATURATION_EN to clamp P on overflow instead of wrapping.
module multiplier_accumulator_stage #(
  parameter logic input_freezed = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [89:0] M,
  input  logic        M_valid,
  input  logic [1:0]  ACC_MODE,
  input  logic        RSTP,
  input  logic        CEP,
  input  logic        PREG,
  output logic [47:0] P,
  output logic        P_valid,
  output logic        OVF,
  input  logic        configuration_input,
  input  logic        configuration_enable,
  output logic        configuration_output
);
  logic        r_is_rstp_inv;
  logic [47:0] r_p;
  logic        r_p_valid;
  logic        r_ovf;
  logic        w_rstp_x;
  logic        w_go;
  logic        w_ovf;
  logic [47:0] w_product;
  logic [47:0] w_acc_res;
  logic [47:0] w_acc_val;
  logic [47:0] w_p_next;
  logic        w_p_valid_next;
  logic        w_ovf_next;
  assign w_product = {{3{M[44]}}, M[44:0]} + {{3{M[89]}}, M[89:45]};
  assign w_rstp_x  = RSTP ^ r_is_rstp_inv;
  assign w_go      = CEP & M_valid & ~w_rstp_x;
  assign w_acc_res = ACC_MODE[0] ? r_p - w_product : r_p + w_product;
  // Subtraction flips the operand sign; overflow when operands agree but result sign differs.
  assign w_ovf = (r_p[47] == (w_product[47] ^ ACC_MODE[0])) && (w_acc_res[47] != r_p[47]);
`ifdef ACC_SATURATION_EN
  assign w_acc_val = w_ovf ? (r_p[47] ? 48'h8000_0000_0000 : 48'h7FFF_FFFF_FFFF) : w_acc_res;
`else
  assign w_acc_val = w_acc_res;
`endif
  assign w_p_next = w_rstp_x ? '0 :
                    !w_go ? r_p :
                    ACC_MODE == 2'b01 ? w_product :
                    ACC_MODE[1] ? w_acc_val : r_p;
  assign w_ovf_next = w_rstp_x ? 1'b0 :
                      (w_go && ACC_MODE == 2'b01) ? 1'b0 :
                      r_ovf | (w_go && ACC_MODE[1] && w_ovf);
  assign w_p_valid_next = w_go && ACC_MODE != 2'b00;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_rstp_inv <= 1'b0;
      r_p           <= '0;
      r_p_valid     <= 1'b0;
      r_ovf         <= 1'b0;
    end else begin
      if (configuration_enable) r_is_rstp_inv <= configuration_input;
      r_p       <= w_p_next;
      r_p_valid <= w_p_valid_next;
      r_ovf     <= w_ovf_next;
    end
  end
  assign P                    = (PREG | input_freezed) ? r_p : w_p_next;
  assign P_valid              = (PREG | input_freezed) ? r_p_valid : w_p_valid_next;
  assign OVF                  = r_ovf;
  assign configuration_output = r_is_rstp_inv;
endmodule

// File: tb/tb_multiplier_accumulator_stage.sv
// tb_multiplier_accumulator_stage: directed and randomized checks against an arithmetic reference model.
module tb_multiplier_accumulator_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [89:0] M = '0;
  logic        M_valid = 1'b0;
  logic [1:0]  ACC_MODE = 2'b00;
  logic        RSTP = 1'b0;
  logic        CEP = 1'b0;
  logic        PREG = 1'b1;
  logic [47:0] P;
  logic        P_valid;
  logic        OVF;
  logic        configuration_input = 1'b0;
  logic        configuration_enable = 1'b0;
  logic        configuration_output;
  int errs = 0;
  int checks = 0;
  logic [47:0] m_p = '0;
  logic        m_ovf = 1'b0;
  logic        m_pv = 1'b0;
  logic        m_inv = 1'b0;
  logic [47:0] mid_p;
  localparam longint MAXV = (longint'(1) <<< 47) - 1;
  localparam longint MINV = -(longint'(1) <<< 47);

  multiplier_accumulator_stage dut (
    .clk(clk), .rst_n(rst_n), .M(M), .M_valid(M_valid), .ACC_MODE(ACC_MODE),
    .RSTP(RSTP), .CEP(CEP), .PREG(PREG), .P(P), .P_valid(P_valid), .OVF(OVF),
    .configuration_input(configuration_input), .configuration_enable(configuration_enable),
    .configuration_output(configuration_output)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle from posedge+1, checks at negedge, advances the model at the edge.
  task automatic cyc(input logic [89:0] m, input logic mv, input logic [1:0] mode,
                     input logic rstp, input logic cep, input logic preg,
                     input logic cin, input logic cen);
    logic signed [44:0] lo45, hi45;
    logic signed [47:0] sp, sprod;
    longint pl, prodl, exact;
    logic [47:0] prod, np;
    logic rx, go, ov, nov, npv;
    M = m; M_valid = mv; ACC_MODE = mode; RSTP = rstp; CEP = cep; PREG = preg;
    configuration_input = cin; configuration_enable = cen;
    lo45 = m[44:0];
    hi45 = m[89:45];
    prodl = longint'(lo45) + longint'(hi45);
    prod = prodl[47:0];
    sprod = prod;
    sp = m_p;
    pl = sp;
    exact = (mode == 2'b11) ? pl - longint'(sprod) : pl + longint'(sprod);
    ov = exact > MAXV || exact < MINV;
    rx = rstp ^ m_inv;
    go = cep && mv && !rx;
    np = m_p;
    if (rx) np = '0;
    else if (go && mode == 2'b01) np = prod;
    else if (go && mode[1]) begin
      np = exact[47:0];
`ifdef ACC_SATURATION_EN
      if (exact > MAXV) np = 48'h7FFF_FFFF_FFFF;
      if (exact < MINV) np = 48'h8000_0000_0000;
`endif
    end
    nov = rx ? 1'b0 : (go && mode == 2'b01) ? 1'b0 : (m_ovf || (go && mode[1] && ov));
    npv = go && mode != 2'b00;
    #4;
    mid_p = P;
    chk("P", P, preg ? m_p : np);
    chk("P_valid", P_valid, preg ? m_pv : npv);
    chk("OVF", OVF, m_ovf);
    chk("cfg_out", configuration_output, m_inv);
    @(posedge clk);
    m_p = np; m_ovf = nov; m_pv = npv;
    if (cen) m_inv = cin;
    #1;
  endtask

  task automatic do_reset();
    PREG = 1'b1;
    rst_n = 1'b0;
    m_p = '0; m_ovf = 1'b0; m_pv = 1'b0; m_inv = 1'b0;
    #2;
    chk("rst_P", P, 48'd0);
    chk("rst_P_valid", P_valid, 1'b0);
    chk("rst_OVF", OVF, 1'b0);
    chk("rst_cfg", configuration_output, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] a, b;
    logic [44:0] big;
    logic [1:0] md;
    #1;
    do_reset();
    // Load then accumulate 7 three times.
    cyc({45'd3, 45'd4}, 1, 2'b01, 0, 1, 1, 0, 0);
    chk("load7", P, 48'd7);
    chk("load7_v", P_valid, 1'b1);
    for (int i = 2; i <= 4; i++) begin
      cyc({45'd3, 45'd4}, 1, 2'b10, 0, 1, 1, 0, 0);
      chk("acc", P, 48'(7 * i));
      chk("acc_v", P_valid, 1'b1);
    end
    cyc({45'd3, 45'd4}, 1, 2'b11, 0, 1, 1, 0, 0);
    chk("sub", P, 48'd21);
    cyc({45'd3, 45'd4}, 1, 2'b00, 0, 1, 1, 0, 0);
    chk("hold_v", P_valid, 1'b0);
    cyc({45'd3, 45'd4}, 0, 2'b10, 0, 1, 1, 0, 0);
    chk("mv0_hold", P, 48'd21);
    // Build 2^47-1, then push it over the top.
    big = 45'h0FFF_FFFF_FFFF;
    cyc({big, big}, 1, 2'b01, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc({big, big}, 1, 2'b10, 0, 1, 1, 0, 0);
    cyc({45'd3, 45'd4}, 1, 2'b10, 0, 1, 1, 0, 0);
    chk("max", P, 48'h7FFF_FFFF_FFFF);
    chk("max_ovf", OVF, 1'b0);
    cyc({45'd0, 45'd1}, 1, 2'b10, 0, 1, 1, 0, 0);
    chk("ovf_set", OVF, 1'b1);
`ifdef ACC_SATURATION_EN
    chk("ovf_P", P, 48'h7FFF_FFFF_FFFF);
`else
    chk("ovf_P", P, 48'h8000_0000_0000);
`endif
    cyc({45'd0, 45'd0}, 1, 2'b10, 0, 1, 1, 0, 0);
    chk("ovf_sticky", OVF, 1'b1);
    cyc({45'd0, 45'd5}, 1, 2'b01, 0, 1, 1, 0, 0);
    chk("ovf_clr_load", OVF, 1'b0);
    // Invert RSTP polarity through the config chain.
    cyc({45'd0, 45'd0}, 0, 2'b00, 0, 0, 1, 1, 1);
    chk("cfg_one", configuration_output, 1'b1);
    cyc({45'd0, 45'd1}, 1, 2'b10, 1, 1, 1, 0, 0);
    chk("inv_acc", P, 48'd6);
    cyc({45'd0, 45'd1}, 1, 2'b10, 0, 1, 1, 0, 0);
    chk("rstp_P", P, 48'd0);
    chk("rstp_v", P_valid, 1'b0);
    chk("rstp_ovf", OVF, 1'b0);
    cyc({45'd0, 45'd0}, 0, 2'b00, 1, 0, 1, 0, 1);
    cyc({45'd2, 45'd5}, 1, 2'b01, 0, 1, 0, 0, 0);
    chk("comb_P", mid_p, 48'd7);
    cyc({45'd0, 45'd0}, 0, 2'b00, 0, 0, 1, 0, 0);
    chk("preg_after", mid_p, 48'd7);
    // Negative partials: -1 + -2 loads -3.
    cyc({45'h1FFF_FFFF_FFFE, 45'h1FFF_FFFF_FFFF}, 1, 2'b01, 0, 1, 1, 0, 0);
    chk("neg_load", P, 48'hFFFF_FFFF_FFFD);
    // Mid-accumulation rst_n discards the partial sum.
    do_reset();
    cyc({45'd1, 45'd1}, 1, 2'b10, 0, 1, 1, 0, 0);
    chk("post_rst_acc", P, 48'd2);
    for (int n = 0; n < 600; n++) begin
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) begin
        a = 64'($urandom_range(0, 40)) - 64'd20;
        b = 64'($urandom_range(0, 40)) - 64'd20;
      end
      md = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) do_reset();
      else cyc({b[44:0], a[44:0]}, $urandom_range(0, 7) != 0, md,
               m_inv ^ ($urandom_range(0, 19) == 0), $urandom_range(0, 7) != 0,
               $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
               $urandom_range(0, 29) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/multiplier_accumulator_stage.md
MULTIPLIER_ACCUMULATOR_STAGE -- requirements
Module: multiplier_accumulator_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports clk and rst_n.
REQ-002 Parameter input_freezed, default 1'b0: when 1, the P path SHALL behave as registered regardless of PREG.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 M  input  90  two signed 45-bit partial products from the multiplier output stage: M[44:0] and M[89:45].
REQ-006 M_valid  input  1  M carries a product this cycle.
REQ-007 ACC_MODE  input  2  00 hold, 01 load, 10 accumulate-add, 11 accumulate-subtract.
REQ-008 RSTP  input  1  synchronous P reset, polarity set by configuration bit.
REQ-009 CEP  input  1  P clock enable.
REQ-010 PREG  input  1  static select: 1 registered P, 0 combinational P.
REQ-011 P  output  48  signed accumulator result.
REQ-012 P_valid  output  1  P holds a newly updated result.
REQ-013 OVF  output  1  sticky signed-overflow flag.
REQ-014 configuration_input / configuration_enable  input  1 each; configuration_output  output  1: serial configuration chain.

Function
REQ-015 product SHALL be the sum of both partials, each sign-extended to 48 bits, taken modulo 2^48.
REQ-016 The configuration register IS_RSTP_INVERTED SHALL load configuration_input on a clk edge when configuration_enable=1; configuration_output SHALL equal IS_RSTP_INVERTED.
REQ-017 The effective reset SHALL be rstp_x = RSTP XOR IS_RSTP_INVERTED.
REQ-018 On a clk edge with rstp_x=1, the block SHALL load P_reg=0, OVF=0 and P_valid_reg=0. This SHALL take priority over CEP and M_valid.
REQ-019 On a clk edge with rstp_x=0, CEP=1 and M_valid=1, the next P_reg SHALL follow ACC_MODE:
- 00: P_reg unchanged.
- 01: P_reg = product; OVF cleared.
- 10: P_reg = P_reg + product.
- 11: P_reg = P_reg - product.
REQ-020 In modes 10 and 11, a signed 48-bit overflow SHALL set OVF; OVF SHALL remain set until a load (01), an RSTP reset or a rst_n reset.
REQ-021 On a clk edge with rstp_x=0, P_valid_reg SHALL become (CEP and M_valid and ACC_MODE!=00).
REQ-022 With CEP=0 or M_valid=0 and rstp_x=0, P_reg and OVF SHALL hold.
REQ-023 When PREG or input_freezed is 1, P=P_reg and P_valid=P_valid_reg; latency from M to P SHALL be 1 cycle.
REQ-024 When PREG=0 and input_freezed=0, P SHALL be the next-state value of REQ-019 (combinational, 0 latency), and P_valid SHALL be the next-state value of REQ-021.
REQ-025 When PREG=0, P_reg SHALL still update so that the accumulation continues.
REQ-026 OVF SHALL always be the registered value.

Reset
REQ-027 rst_n=0 SHALL asynchronously clear P_reg, P_valid_reg, OVF and IS_RSTP_INVERTED to 0.
REQ-028 After reset: P=0 (PREG=1), P_valid=0, OVF=0, configuration_output=0.
REQ-029 rst_n asserted mid-accumulation SHALL discard the partial sum; the first valid cycle after release SHALL act on P_reg=0.

Configuration
REQ-030 Macro ACC_SATURATION_EN:
- Defined: on overflow in modes 10/11, P_reg SHALL clamp to 48'h7FFF_FFFF_FFFF on positive overflow or 48'h8000_0000_0000 on negative overflow, and OVF SHALL set.
- Not defined: P_reg SHALL wrap modulo 2^48, and OVF SHALL still set.

Verification
REQ-031 Run rst_n low, then release with PREG=1 -> P=0, P_valid=0, OVF=0, configuration_output=0.
REQ-032 Apply M={45'd3,45'd4}, M_valid=1, CEP=1, ACC_MODE=01, then ACC_MODE=10 for 3 further cycles -> P=7, 14, 21, 28 on successive cycles, each with P_valid=1.
REQ-033 Load P=48'h7FFF_FFFF_FFFF, then accumulate a product of 1 -> OVF=1, and P=48'h8000_0000_0000 (wrap) or 48'h7FFF_FFFF_FFFF (ACC_SATURATION_EN).
REQ-034 Shift configuration_input=1 with configuration_enable=1, then drive RSTP=0 -> P cleared next edge, OVF=0, P_valid=0; with RSTP=1 -> accumulation proceeds.
REQ-035 Drive RSTP effective and CEP=1, M_valid=1, ACC_MODE=10 in the same cycle -> P=0 (reset wins).
REQ-036 Set PREG=0 and apply M={45'd2,45'd5} with ACC_MODE=01 -> P=7 in the same cycle, and P_reg=7 after the edge.
